csa_operand_collector: RTL

CSA_OPERAND_COLLECTOR -- requirements
Module: csa_operand_collector

---
 rtl/csa_operand_collector.sv | 106 ++++++++++
 1 files changed

// File: rtl/csa_operand_collector.sv
`default_nettype none
// ============================================================================
// Module   : csa_operand_collector
// Brief    : Gathers four serial words into an operand group for a 4:2 CSA.
// Revision : 1.0
// ============================================================================
module csa_operand_collector #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] op_c,
    output logic [WIDTH-1:0] op_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       col_cnt,
    output logic [7:0]       grp_count
);

    localparam int         NUM_SLOTS = 4;
    localparam logic [2:0] FULL_CNT  = 3'd4;

    logic [WIDTH-1:0] slot_q [NUM_SLOTS];
    logic [WIDTH-1:0] op_q   [NUM_SLOTS];
    logic [2:0]       col_cnt_q;
    logic [2:0]       col_cnt_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [7:0]       grp_count_q;

    logic             w_xfer;
    logic             w_accept;
    logic             w_drain;
    logic [1:0]       w_wr_idx;

    always_comb begin
        w_xfer   = (col_cnt_q == FULL_CNT) && (!out_valid_q || out_ready) && !flush;
        in_ready = !rst && !flush && ((col_cnt_q < FULL_CNT) || w_xfer);
        w_accept = in_valid && in_ready;
        w_drain  = out_valid_q && out_ready;
        // A word arriving on the transfer edge starts the next group in s0.
        w_wr_idx = w_xfer ? 2'd0 : col_cnt_q[1:0];
    end

    always_comb begin
        col_cnt_d = col_cnt_q;
        if (flush) begin
            col_cnt_d = 3'd0;
        end else if (w_xfer) begin
            col_cnt_d = w_accept ? 3'd1 : 3'd0;
        end else if (w_accept) begin
            col_cnt_d = col_cnt_q + 3'd1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
        end else if (w_drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_q   <= 3'd0;
            out_valid_q <= 1'b0;
            grp_count_q <= 8'd0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
                op_q[i]   <= '0;
            end
        end else begin
            col_cnt_q   <= col_cnt_d;
            out_valid_q <= out_valid_d;
            if (w_accept) begin
                slot_q[w_wr_idx] <= in_data;
            end
            if (w_xfer) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    op_q[i] <= slot_q[i];
                end
            end
            if (w_drain) begin
                grp_count_q <= grp_count_q + 8'd1;
            end
        end
    end

    assign op_a      = op_q[0];
    assign op_b      = op_q[1];
    assign op_c      = op_q[2];
    assign op_d      = op_q[3];
    assign out_valid = out_valid_q;
    assign col_cnt   = col_cnt_q;
    assign grp_count = grp_count_q;

endmodule
`default_nettype wire
